// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the fetch
// stage (read) and the program loader (write). Runs a registered req/ready
// handshake with the memory and range-checks addresses against the text segment.
module imem_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int unsigned IM_WORDS  = 4096,
   localparam int unsigned AW       = $clog2(IM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   // fetch port
   input  logic          f_req,
   input  logic [31:0]   f_pc,
   output logic          f_valid,
   output logic [31:0]   f_instr,
   output logic          pc_fault,
   // loader port
   input  logic          l_req,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   output logic          l_done,
   output logic          l_err,
   // memory port
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata,
   input  logic          m_ready
);

   localparam logic [31:0] END_ADDR = BASE_ADDR + (IM_WORDS << 2);

   typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

   state_e  state_q;
   logic    last_grant_l_q;   // 1 = loader was granted last

   logic          f_elig, l_elig;
   logic          grant_f, grant_l;
   logic          f_legal, l_legal;
   logic [AW-1:0] f_idx, l_idx;

   // No wrap-around: anything below BASE_ADDR or at/after END_ADDR is rejected.
   function automatic logic addr_legal(input logic [31:0] a);
      return (a >= BASE_ADDR) && (a < END_ADDR) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE_ADDR) >> 2;
      return AW'(off);
   endfunction

   // Eligibility, round-robin tie-break and address decode for both requesters.
   always_comb begin
      // A requester whose completion pulse is high is still holding a stale req.
      f_elig  = f_req & ~f_valid;
      l_elig  = l_req & ~l_done;
      grant_f = f_elig & (~l_elig | last_grant_l_q);
      grant_l = l_elig & (~f_elig | ~last_grant_l_q);
      f_legal = addr_legal(f_pc);
      l_legal = addr_legal(l_addr);
      f_idx   = word_idx(f_pc);
      l_idx   = word_idx(l_addr);
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         last_grant_l_q <= 1'b1;   // fetch wins the first tie
         m_req          <= 1'b0;
         m_we           <= 1'b0;
         m_addr         <= '0;
         m_wdata        <= '0;
         f_valid        <= 1'b0;
         f_instr        <= '0;
         pc_fault       <= 1'b0;
         l_done         <= 1'b0;
         l_err          <= 1'b0;
      end else begin
         f_valid  <= 1'b0;
         pc_fault <= 1'b0;
         l_done   <= 1'b0;
         l_err    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_f) begin
                  last_grant_l_q <= 1'b0;
                  if (f_legal) begin
                     state_q <= StRd;
                     m_req   <= 1'b1;
                     m_we    <= 1'b0;
                     m_addr  <= f_idx;
                  end else begin
                     f_valid  <= 1'b1;
                     pc_fault <= 1'b1;
                     f_instr  <= '0;
                  end
               end else if (grant_l) begin
                  last_grant_l_q <= 1'b1;
                  if (l_legal) begin
                     state_q <= StWr;
                     m_req   <= 1'b1;
                     m_we    <= 1'b1;
                     m_addr  <= l_idx;
                     m_wdata <= l_wdata;
                  end else begin
                     l_done <= 1'b1;
                     l_err  <= 1'b1;
                  end
               end
            end
            StRd: begin
               if (m_ready) begin
                  state_q <= StIdle;
                  m_req   <= 1'b0;
                  f_instr <= m_rdata;
                  f_valid <= 1'b1;
               end
            end
            StWr: begin
               if (m_ready) begin
                  state_q <= StIdle;
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  l_done  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               m_req   <= 1'b0;
               m_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule
